// File: rtl/mem_controller.sv
// Three-requester arbiter for one shared memory port. Requesters are served in
// arrival order through a 4-entry ID queue; the winner's bus is muxed out.
module mem_controller #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            requestingMemory,
    output logic [2:0]            grantedAccess,
    output logic                  enabled,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] dataToMem,
    output logic                  readWrite,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [ADDR_WIDTH-1:0] addr3,
    input  logic [DATA_WIDTH-1:0] dataToMem1,
    input  logic [DATA_WIDTH-1:0] dataToMem2,
    input  logic [DATA_WIDTH-1:0] dataToMem3,
    input  logic                  readWrite1,
    input  logic                  readWrite2,
    input  logic                  readWrite3
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      grant_q, grant_d;
    logic            en_q, en_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [3:0][1:0] queue_q, queue_d;
    logic [2:0]      in_queue_q, in_queue_d;
    logic            cand_vld;
    logic [1:0]      cand_id;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 3'b000;
            en_q       <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            queue_q    <= '0;
            in_queue_q <= 3'b000;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            en_q       <= en_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            queue_q    <= queue_d;
            in_queue_q <= in_queue_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        en_d       = en_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        queue_d    = queue_q;
        in_queue_d = in_queue_q;
        cand_vld   = 1'b0;
        cand_id    = 2'd0;

        // Scan downwards so the lowest-index eligible requester wins.
        for (int i = 2; i >= 0; i--) begin
            if (requestingMemory[i] && !in_queue_q[i]) begin
                cand_vld = 1'b1;
                cand_id  = 2'(i);
            end
        end

        case (state_q)
            IDLE: begin
                if (wr_ptr_q != rd_ptr_q) begin
                    grant_d = 3'b001 << queue_q[rd_ptr_q];
                    en_d    = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if ((requestingMemory & grant_q) == 3'b000) begin
                    grant_d    = 3'b000;
                    en_d       = 1'b0;
                    in_queue_d = in_queue_q & ~grant_q;
                    rd_ptr_d   = rd_ptr_q + 2'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The granted requester still holds its inQueue bit, so it is never
        // the candidate here and the two in_queue_d updates cannot collide.
        if (cand_vld) begin
            queue_d[wr_ptr_q] = cand_id;
            wr_ptr_d          = wr_ptr_q + 2'd1;
            in_queue_d        = in_queue_d | (3'b001 << cand_id);
        end
    end

    always_comb begin
        address   = '0;
        dataToMem = '0;
        readWrite = 1'b0;
        case (grant_q)
            3'b001: begin
                address   = addr1;
                dataToMem = dataToMem1;
                readWrite = readWrite1;
            end
            3'b010: begin
                address   = addr2;
                dataToMem = dataToMem2;
                readWrite = readWrite2;
            end
            3'b100: begin
                address   = addr3;
                dataToMem = dataToMem3;
                readWrite = readWrite3;
            end
            default: ;
        endcase
    end

    assign grantedAccess = grant_q;
    assign enabled       = en_q;

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based arrival-order arbiter model.
module tb_mem_controller;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [2:0]            requestingMemory;
    logic [2:0]            grantedAccess;
    logic                  enabled;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] dataToMem;
    logic                  readWrite;
    logic [ADDR_WIDTH-1:0] addr1, addr2, addr3;
    logic [DATA_WIDTH-1:0] dataToMem1, dataToMem2, dataToMem3;
    logic                  readWrite1, readWrite2, readWrite3;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO of requester indices, membership flags, current grant
    int m_q[$];
    bit m_inq[3];
    int m_gnt = -1;

    mem_controller #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .requestingMemory(requestingMemory),
        .grantedAccess(grantedAccess), .enabled(enabled), .address(address),
        .dataToMem(dataToMem), .readWrite(readWrite),
        .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .dataToMem1(dataToMem1), .dataToMem2(dataToMem2), .dataToMem3(dataToMem3),
        .readWrite1(readWrite1), .readWrite2(readWrite2), .readWrite3(readWrite3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        int cand = -1;
        if (!rst_n) begin
            m_q.delete();
            foreach (m_inq[i]) m_inq[i] = 1'b0;
            m_gnt = -1;
        end else begin
            for (int i = 0; i < 3; i++)
                if (cand < 0 && requestingMemory[i] && !m_inq[i]) cand = i;
            if (m_gnt >= 0) begin
                if (!requestingMemory[m_gnt]) begin
                    m_inq[m_gnt] = 1'b0;
                    void'(m_q.pop_front());
                    m_gnt = -1;
                end
            end else if (m_q.size() > 0) begin
                m_gnt = m_q[0];
            end
            if (cand >= 0) begin
                m_q.push_back(cand);
                m_inq[cand] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [2:0]            eg;
        logic [ADDR_WIDTH-1:0] ea;
        logic [DATA_WIDTH-1:0] ed;
        logic                  er;
        eg = 3'b000; ea = '0; ed = '0; er = 1'b0;
        case (m_gnt)
            0: begin eg = 3'b001; ea = addr1; ed = dataToMem1; er = readWrite1; end
            1: begin eg = 3'b010; ea = addr2; ed = dataToMem2; er = readWrite2; end
            2: begin eg = 3'b100; ea = addr3; ed = dataToMem3; er = readWrite3; end
            default: ;
        endcase
        chk("grant",   32'(grantedAccess), 32'(eg));
        chk("enabled", 32'(enabled),       32'(m_gnt >= 0));
        chk("address", 32'(address),       32'(ea));
        chk("data",    dataToMem,          ed);
        chk("rw",      32'(readWrite),     32'(er));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic fixed_bus();
        addr1 = 8'hA1; addr2 = 8'hA2; addr3 = 8'hA3;
        dataToMem1 = 32'hD1D1_0001; dataToMem2 = 32'hD2D2_0002; dataToMem3 = 32'hD3D3_0003;
        readWrite1 = 1'b0; readWrite2 = 1'b1; readWrite3 = 1'b0;
    endtask

    task automatic random_bus();
        addr1 = 8'($urandom); addr2 = 8'($urandom); addr3 = 8'($urandom);
        dataToMem1 = $urandom; dataToMem2 = $urandom; dataToMem3 = $urandom;
        readWrite1 = 1'($urandom); readWrite2 = 1'($urandom); readWrite3 = 1'($urandom);
    endtask

    initial begin
        int cnt[3];
        int last, idle_cnt, idx;
        logic [2:0] prev_g;

        fixed_bus();
        requestingMemory = 3'b000;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_grant", 32'(grantedAccess), 32'h0);

        // All three request from reset release
        rst_n = 1'b1;
        requestingMemory = 3'b111;
        step();
        chk("no_grant_e1", 32'(grantedAccess), 32'h0);
        step();
        chk("first_grant", 32'(grantedAccess), 32'h1);
        step();
        step();

        // Clients hold 4 granted cycles, then re-request once enabled is low
        foreach (cnt[i]) cnt[i] = 0;
        last = 0; idle_cnt = 0; prev_g = grantedAccess;
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (grantedAccess[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 4) begin
                        requestingMemory[i] = 1'b0;
                        cnt[i] = 0;
                    end
                end else if (!requestingMemory[i] && !enabled) begin
                    requestingMemory[i] = 1'b1;
                end
            end
            step();
            if (grantedAccess == 3'b000) idle_cnt++;
            else if (prev_g == 3'b000) begin
                idx = (grantedAccess == 3'b001) ? 0 : (grantedAccess == 3'b010) ? 1 : 2;
                chk("rr_order", 32'(idx), 32'((last + 1) % 3));
                chk("rr_gap", 32'(idle_cnt), 32'd1);
                last = idx;
                idle_cnt = 0;
            end
            prev_g = grantedAccess;
        end

        // Only requester 3
        rst_n = 1'b0; requestingMemory = 3'b000;
        step();
        rst_n = 1'b1; requestingMemory = 3'b100;
        step();
        step();
        chk("r3_grant", 32'(grantedAccess), 32'h4);
        step();
        step();
        requestingMemory = 3'b000;
        step();
        chk("r3_release", 32'(enabled), 32'h0);
        step(); step(); step();
        chk("r3_stays_off", 32'(grantedAccess), 32'h0);

        // Requester 2 drops its request while queued behind requester 1
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; requestingMemory = 3'b111;
        step(); step(); step();
        requestingMemory = 3'b101;
        step(); step();
        requestingMemory = 3'b100;
        step();
        chk("r1_released", 32'(grantedAccess), 32'h0);
        step();
        chk("dropped_r2_grant", 32'(grantedAccess), 32'h2);
        step();
        chk("dropped_r2_rel", 32'(grantedAccess), 32'h0);
        step();
        chk("r3_after_drop", 32'(grantedAccess), 32'h4);

        // Reset during an active grant
        rst_n = 1'b0;
        step();
        chk("midrst_grant", 32'(grantedAccess), 32'h0);
        chk("midrst_en", 32'(enabled), 32'h0);
        rst_n = 1'b1; requestingMemory = 3'b111;
        step(); step();
        chk("restart_r1", 32'(grantedAccess), 32'h1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            random_bus();
            for (int i = 0; i < 3; i++)
                if ($urandom_range(5) == 0) requestingMemory[i] = ~requestingMemory[i];
            rst_n = ($urandom_range(299) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
